// File: rtl/logic_pad_coincidence_generator.sv
// Multi-layer pad coincidence trigger: selects one bit per layer, ORs hits over a
// programmable window, looks the closed pattern up in a match map, then applies deadtime.
module logic_pad_coincidence_generator #(
  parameter int N_LAYER = 4,
  parameter int PAD_W   = 104,
  parameter int MAP_W   = 2**N_LAYER
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_valid_in,
  input  logic [N_LAYER*PAD_W-1:0] pad_data,
  input  logic [N_LAYER*8-1:0]     pad_data_mask,
  input  logic [MAP_W-1:0]         pad_matched_map,
  input  logic [3:0]               window_len,
  input  logic [7:0]               deadtime,
  output logic                     pad_hited,
  output logic                     pad_hited_clear,
  output logic [N_LAYER-1:0]       pattern_out,
  output logic                     busy,
  output logic [15:0]              hit_count
);

  localparam logic [7:0] PAD_LIM = 8'(PAD_W);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DEAD    = 2'd2
  } state_t;

  // Stage 1: per-layer bit selection
  logic [N_LAYER-1:0] layer_sel;
  logic [N_LAYER-1:0] layer_hit_reg;
  logic               valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_LAYER; gi++) begin : g_layer
      logic [7:0]   mask_byte;
      logic [127:0] word_ext;
      assign mask_byte = pad_data_mask[gi*8 +: 8];
      assign word_ext  = 128'(pad_data[gi*PAD_W +: PAD_W]);
      assign layer_sel[gi] = !mask_byte[7]
                             && ({1'b0, mask_byte[6:0]} < PAD_LIM)
                             && word_ext[mask_byte[6:0]];
    end
  endgenerate

  // Stage 2: window / deadtime FSM
  state_t             state_reg, state_next;
  logic [N_LAYER-1:0] acc_reg, acc_next;
  logic [3:0]         win_cnt_reg, win_cnt_next;
  logic [3:0]         win_len_reg, win_len_next;
  logic [7:0]         dead_cnt_reg, dead_cnt_next;
  logic               holdoff_reg;
  logic               pad_hited_reg;
  logic               clear_reg;
  logic [N_LAYER-1:0] pattern_reg;
  logic [15:0]        hit_count_reg, hit_count_next;

  logic               close;
  logic               matched;
  logic [N_LAYER-1:0] close_pat;

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    win_cnt_next  = win_cnt_reg;
    win_len_next  = win_len_reg;
    dead_cnt_next = dead_cnt_reg;
    close         = 1'b0;
    close_pat     = acc_reg | layer_hit_reg;

    unique case (state_reg)
      ST_IDLE: begin
        // The cycle right after a close is not armed, so pulses can never be back to back.
        if (!holdoff_reg && (layer_hit_reg != '0)) begin
          acc_next     = layer_hit_reg;
          win_cnt_next = 4'd0;
          win_len_next = window_len;
          close_pat    = layer_hit_reg;
          if (window_len == 4'd0) begin
            close = 1'b1;
          end else begin
            state_next = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        acc_next     = close_pat;
        win_cnt_next = win_cnt_reg + 4'd1;
        if ((win_cnt_reg + 4'd1) == win_len_reg) begin
          close = 1'b1;
        end
      end
      ST_DEAD: begin
        dead_cnt_next = dead_cnt_reg - 8'd1;
        if (dead_cnt_reg <= 8'd1) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    matched = close && pad_matched_map[close_pat];

    if (close) begin
      if (matched && (deadtime != 8'd0)) begin
        state_next    = ST_DEAD;
        dead_cnt_next = deadtime;
      end else begin
        state_next = ST_IDLE;
      end
    end

    hit_count_next = (matched && (hit_count_reg != 16'hFFFF)) ? hit_count_reg + 16'd1
                                                              : hit_count_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      layer_hit_reg <= '0;
      valid_reg     <= 1'b0;
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      win_cnt_reg   <= 4'd0;
      win_len_reg   <= 4'd0;
      dead_cnt_reg  <= 8'd0;
      holdoff_reg   <= 1'b0;
      pad_hited_reg <= 1'b0;
      clear_reg     <= 1'b0;
      pattern_reg   <= '0;
      hit_count_reg <= 16'd0;
    end else begin
      layer_hit_reg <= data_valid_in ? layer_sel : '0;
      valid_reg     <= data_valid_in;
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      win_cnt_reg   <= win_cnt_next;
      win_len_reg   <= win_len_next;
      dead_cnt_reg  <= dead_cnt_next;
      holdoff_reg   <= close;
      pad_hited_reg <= matched;
      clear_reg     <= matched && valid_reg;
      if (close) begin
        pattern_reg <= close_pat;
      end
      hit_count_reg <= hit_count_next;
    end
  end

  assign pad_hited       = pad_hited_reg;
  assign pad_hited_clear = clear_reg;
  assign pattern_out     = pattern_reg;
  assign busy            = (state_reg != ST_IDLE);
  assign hit_count       = hit_count_reg;

endmodule

// File: tb/tb_logic_pad_coincidence_generator.sv
// Self-checking bench: table of single-shot trigger vectors plus hand sequences for
// windows, deadtime, back-to-back suppression, reset abandonment and counter saturation.
module tb_logic_pad_coincidence_generator;

  localparam int NL = 4;
  localparam int PW = 104;
  localparam int MW = 16;
  localparam logic [31:0] STD_MASK = 32'h6732_1103;

  logic             clk = 1'b0;
  logic             rst;
  logic             data_valid_in;
  logic [NL*PW-1:0] pad_data;
  logic [NL*8-1:0]  pad_data_mask;
  logic [MW-1:0]    pad_matched_map;
  logic [3:0]       window_len;
  logic [7:0]       deadtime;
  logic             pad_hited;
  logic             pad_hited_clear;
  logic [NL-1:0]    pattern_out;
  logic             busy;
  logic [15:0]      hit_count;

  logic_pad_coincidence_generator #(.N_LAYER(NL), .PAD_W(PW)) dut (
    .clk(clk), .rst(rst), .data_valid_in(data_valid_in), .pad_data(pad_data),
    .pad_data_mask(pad_data_mask), .pad_matched_map(pad_matched_map),
    .window_len(window_len), .deadtime(deadtime), .pad_hited(pad_hited),
    .pad_hited_clear(pad_hited_clear), .pattern_out(pattern_out), .busy(busy),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_count = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        valid;
    logic [3:0]  hits;
    logic [31:0] mask;
    logic [15:0] map;
    logic [3:0]  wl;
    logic        exp_hit;
    logic        exp_clr;
    logic [3:0]  exp_pat;
  } vec_t;

  typedef struct {
    int         due;
    logic       hit;
    logic       clr;
    logic [3:0] pat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vec[10];
  logic prev_hited = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push(input int due, input logic hit, input logic clr, input logic [3:0] pat);
    exp_t e;
    e.due = due; e.hit = hit; e.clr = clr; e.pat = pat;
    sb.push_back(e);
    if (hit) exp_count++;
  endfunction

  // Scoreboard monitor: compares due expectations and flags any unexpected pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_hited = 1'b0;
    end else begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        tests++; fails++;
        $display("FAIL stale_event: due cycle %0d not checked, now %0d", mon_e.due, cyc);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("pad_hited", 32'(pad_hited), 32'(mon_e.hit));
        chk("pad_hited_clear", 32'(pad_hited_clear), 32'(mon_e.clr));
        chk("pattern_out", 32'(pattern_out), 32'(mon_e.pat));
        $display("[TB] cycle %0d: pad_hited=%0b clear=%0b pattern=%0h count=%0d", cyc,
                 pad_hited, pad_hited_clear, pattern_out, hit_count);
      end else if (pad_hited) begin
        tests++; fails++;
        $display("FAIL unexpected_pulse: got pad_hited=1, expected 0 (cycle %0d)", cyc);
      end
      if (pad_hited) chk("no_back_to_back", 32'(prev_hited), 32'd0);
      prev_hited = pad_hited;
    end
  end

  task automatic drive(input logic v, input logic [3:0] hits, input logic [31:0] mask);
    logic [NL*PW-1:0] d;
    @(posedge clk); #1;
    for (int i = 0; i < NL; i++) begin
      logic [7:0] m;
      m = mask[i*8 +: 8];
      for (int b = 0; b < PW; b++) d[i*PW+b] = 1'($urandom_range(0, 1));
      if (int'(m[6:0]) < PW) d[i*PW + int'(m[6:0])] = m[7] ? 1'b1 : hits[i];
    end
    data_valid_in = v;
    pad_data      = d;
    pad_data_mask = mask;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      data_valid_in = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int busy_cnt;
    vec[0] = '{1'b1, 4'hF, STD_MASK,     16'h8000, 4'd0, 1'b1, 1'b1, 4'hF};
    vec[1] = '{1'b1, 4'hF, 32'h67B21103, 16'h0800, 4'd0, 1'b1, 1'b1, 4'hB};
    vec[2] = '{1'b1, 4'hF, 32'h67781103, 16'h0800, 4'd4, 1'b1, 1'b0, 4'hB};
    vec[3] = '{1'b1, 4'hF, 32'h67B21103, 16'h8000, 4'd0, 1'b0, 1'b0, 4'hB};
    vec[4] = '{1'b1, 4'h5, 32'h03020100, 16'h0020, 4'd2, 1'b1, 1'b0, 4'h5};
    vec[5] = '{1'b1, 4'h3, STD_MASK,     16'h0000, 4'd1, 1'b0, 1'b0, 4'h3};
    vec[6] = '{1'b1, 4'h8, STD_MASK,     16'h0100, 4'd0, 1'b1, 1'b1, 4'h8};
    vec[7] = '{1'b1, 4'h0, STD_MASK,     16'hFFFF, 4'd0, 1'b0, 1'b0, 4'h8};
    vec[8] = '{1'b0, 4'hF, STD_MASK,     16'hFFFF, 4'd0, 1'b0, 1'b0, 4'h8};
    vec[9] = '{1'b1, 4'h6, 32'h677F0003, 16'h0004, 4'd0, 1'b1, 1'b1, 4'h2};

    rst = 1'b1; data_valid_in = 1'b0; pad_data = '0; pad_data_mask = '0;
    pad_matched_map = '0; window_len = 4'd0; deadtime = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_pad_hited", 32'(pad_hited), 32'd0);
    chk("reset_clear", 32'(pad_hited_clear), 32'd0);
    chk("reset_pattern", 32'(pattern_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hit_count", 32'(hit_count), 32'd0);

    // Table-driven single-shot vectors
    for (int t = 0; t < 10; t++) begin
      window_len = vec[t].wl;
      pad_matched_map = vec[t].map;
      drive(vec[t].valid, vec[t].hits, vec[t].mask);
      push(cyc + 2 + int'(vec[t].wl), vec[t].exp_hit, vec[t].exp_clr, vec[t].exp_pat);
      $display("[TB] vec %0d: valid=%0b hits=%0h mask=%08h map=%04h wl=%0d", t, vec[t].valid,
               vec[t].hits, vec[t].mask, vec[t].map, vec[t].wl);
      idle(int'(vec[t].wl) + 6);
    end
    chk("hit_count_table", 32'(hit_count), 32'(exp_count));

    // Window of 3 collecting one layer per cycle; window_len change mid-window ignored
    window_len = 4'd3; pad_matched_map = 16'h8000;
    drive(1'b1, 4'h1, STD_MASK);
    c0 = cyc;
    push(c0 + 5, 1'b1, 1'b1, 4'hF);
    drive(1'b1, 4'h2, STD_MASK);
    drive(1'b1, 4'h4, STD_MASK);
    window_len = 4'd15;
    drive(1'b1, 4'h8, STD_MASK);
    idle(8);
    $display("[TB] window_len=3 layered sequence done");

    // Deadtime 10 with continuous all-layer hits
    window_len = 4'd0; deadtime = 8'd10; busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 4'hF, STD_MASK);
      if (k == 0) begin
        c0 = cyc;
        push(c0 + 2, 1'b1, 1'b1, 4'hF);
        push(c0 + 13, 1'b1, 1'b1, 4'hF);
      end
      @(negedge clk);
      if (k >= 1 && k <= 12 && busy) busy_cnt++;
      if (k == 12) chk("busy_after_dead", 32'(busy), 32'd0);
      if (k == 13) chk("busy_redead", 32'(busy), 32'd1);
    end
    chk("busy_dead_cycles", 32'(busy_cnt), 32'd10);
    idle(8);
    deadtime = 8'd0;
    idle(2);

    // Continuous hits, no deadtime: pulses every other cycle
    drive(1'b1, 4'hF, STD_MASK);
    c0 = cyc;
    for (int j = 0; j < 5; j++) push(c0 + 2 + 2*j, 1'b1, 1'b1, 4'hF);
    repeat (9) drive(1'b1, 4'hF, STD_MASK);
    idle(6);
    chk("hit_count_running", 32'(hit_count), 32'(exp_count));

    // Reset in the middle of a window
    window_len = 4'd5; pad_matched_map = 16'hFFFF;
    drive(1'b1, 4'hF, STD_MASK);
    idle(2);
    @(negedge clk);
    chk("busy_in_collect", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pad_hited", 32'(pad_hited), 32'd0);
    chk("rst_clear", 32'(pad_hited_clear), 32'd0);
    chk("rst_pattern", 32'(pattern_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    idle(12);

    // Saturation of hit_count
    window_len = 4'd0; pad_matched_map = 16'h8000;
    @(negedge clk);
    force dut.hit_count_reg = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.hit_count_reg;
    drive(1'b1, 4'hF, STD_MASK);
    push(cyc + 2, 1'b1, 1'b1, 4'hF);
    idle(4);
    chk("hit_count_sat1", 32'(hit_count), 32'hFFFF);
    drive(1'b1, 4'hF, STD_MASK);
    push(cyc + 2, 1'b1, 1'b1, 4'hF);
    idle(4);
    chk("hit_count_sat2", 32'(hit_count), 32'hFFFF);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
